// File: rtl/trivium_kiv_loader.sv
// Byte-serial key/IV loader for a Trivium core: gathers 10 key + 10 IV bytes, then runs Krdy/Drdy to Done.
// Optional TRIVIUM_LOADER_KEYREUSE_EN adds Bivonly so a load can refresh only the IV and keep the key.
module trivium_kiv_loader (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [7:0]  Bin,
  input  logic        Bvld,
  input  logic        Bfirst,
`ifdef TRIVIUM_LOADER_KEYREUSE_EN
  input  logic        Bivonly,
`endif
  output logic        Brdy,
  output logic [79:0] Kout,
  output logic [79:0] Ivout,
  output logic        Krdy,
  output logic        Drdy,
  input  logic        BSY,
  input  logic        Kvld,
  input  logic        Dvld,
  output logic        Done,
  output logic        Err,
  output logic [2:0]  dbg_state
);

  // Handshake: the host byte transfers on a rising CLK edge where Bvld and Brdy are both 1;
  // Brdy depends only on state, never on Bvld, so the host may hold Bvld while waiting.
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_KEY  = 3'd1;
  localparam logic [2:0] ST_IV   = 3'd2;
  localparam logic [2:0] ST_LDK  = 3'd3;
  localparam logic [2:0] ST_WKV  = 3'd4;
  localparam logic [2:0] ST_LDD  = 3'd5;
  localparam logic [2:0] ST_WBSY = 3'd6;
  localparam logic [2:0] ST_WDV  = 3'd7;

  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [79:0] kout_q, kout_d;
  logic [79:0] ivout_q, ivout_d;
  logic        krdy_q, krdy_d;
  logic        drdy_q, drdy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        accept;
  logic        iv_only;

`ifdef TRIVIUM_LOADER_KEYREUSE_EN
  assign iv_only = Bivonly;
`else
  assign iv_only = 1'b0;
`endif

  assign Brdy   = (state_q == ST_IDLE) || (state_q == ST_KEY) || (state_q == ST_IV);
  assign accept = Bvld & Brdy;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kout_d  = kout_q;
    ivout_d = ivout_q;
    err_d   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_KEY, ST_IV: begin
        if (accept) begin
          if (Bfirst) begin
            // A first-byte marker restarts the load; stale bytes are simply overwritten later.
            cnt_d = 4'd1;
            if (iv_only) begin
              ivout_d[7:0] = Bin;
              state_d      = ST_IV;
            end else begin
              kout_d[7:0] = Bin;
              state_d     = ST_KEY;
            end
          end else if (state_q == ST_IDLE) begin
            err_d = 1'b1;
          end else if (state_q == ST_KEY) begin
            for (int i = 0; i < 10; i++) begin
              if (cnt_q == 4'(i)) kout_d[8*i +: 8] = Bin;
            end
            if (cnt_q == 4'd9) begin
              cnt_d   = 4'd0;
              state_d = ST_IV;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            for (int i = 0; i < 10; i++) begin
              if (cnt_q == 4'(i)) ivout_d[8*i +: 8] = Bin;
            end
            if (cnt_q == 4'd9) begin
              cnt_d   = 4'd0;
              state_d = ST_LDK;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
      end
      ST_LDK:  state_d = ST_WKV;
      ST_WKV:  if (Kvld) state_d = ST_LDD;
      ST_LDD:  state_d = ST_WBSY;
      ST_WBSY: if (BSY) state_d = ST_WDV;
      ST_WDV: begin
        if (Dvld) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Krdy coincides with the LDK state; Drdy is issued on leaving LDD, so the two never overlap.
  assign krdy_d = (state_d == ST_LDK);
  assign drdy_d = (state_q == ST_LDD);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      kout_q  <= 80'd0;
      ivout_q <= 80'd0;
      krdy_q  <= 1'b0;
      drdy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kout_q  <= kout_d;
      ivout_q <= ivout_d;
      krdy_q  <= krdy_d;
      drdy_q  <= drdy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign Kout      = kout_q;
  assign Ivout     = ivout_q;
  assign Krdy      = krdy_q;
  assign Drdy      = drdy_q;
  assign Done      = done_q;
  assign Err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: doc/trivium_kiv_loader.md
# trivium_kiv_loader

Byte-serial key/IV loader that sits directly upstream of the Trivium keystream core. It collects a 10-byte key and a 10-byte IV from a host byte stream and presents them as the core's 80-bit Kin/Din buses. It then sequences the core's Krdy/Drdy handshake and reports completion once the core raises Dvld. One load is in flight at a time, and the host is back-pressured with Brdy.

## Interface
- No parameters; key and IV lengths are fixed at 10 bytes each.
- CLK  in  1  system clock, rising edge.
- RSTn  in  1  reset; one clock; reset is asynchronous and active-low.
- Bin  in  8  host data byte.
- Bvld  in  1  Bin valid; a byte is accepted on a rising edge with Bvld & Brdy.
- Bfirst  in  1  qualifies the accepted byte as byte 0 of a new load.
- Bivonly  in  1  only with TRIVIUM_LOADER_KEYREUSE_EN; sampled with Bfirst.
- Brdy  out  1  loader can accept a byte.
- Kout  out  80  key to core Kin; byte i at [8i+7:8i].
- Ivout  out  80  IV to core Din; byte i at [8i+7:8i].
- Krdy  out  1  one-cycle key-load strobe to core.
- Drdy  out  1  one-cycle start strobe to core.
- BSY  in  1  core busy.
- Kvld  in  1  core key-accepted pulse.
- Dvld  in  1  core keystream-done pulse.
- Done  out  1  one-cycle pulse: load and keystream run complete.
- Err  out  1  one-cycle pulse: protocol error on the byte interface.

## Operation
- States: IDLE, KEY, IV, LDK, WKV, LDD, WBSY, WDV.
- Byte counter cnt is 4 bits and runs 0..9. Bytes in each phase fill from byte 0 upward; the first byte received lands in [7:0].
- Brdy = 1 in IDLE, KEY and IV. It is 0 in all other states.
- Accepted byte with Bfirst, in IDLE, KEY or IV:
  - The byte is written to Kout byte 0 and cnt becomes 1.
  - State goes to KEY.
  - This restarts any partial load. Previously collected bytes are not cleared but will be overwritten.
- Accepted byte without Bfirst in IDLE: the byte is dropped, Err pulses, and state stays IDLE.
- KEY: the byte is written to Kout byte cnt and cnt increments. After byte 9, cnt becomes 0 and state goes to IV.
- IV: the byte is written to Ivout byte cnt and cnt increments. After byte 9, state goes to LDK.
- LDK: Krdy = 1 for exactly one cycle, then state goes to WKV.
- WKV: wait for Kvld = 1, then go to LDD.
- LDD: Drdy = 1 for exactly one cycle, then state goes to WBSY.
- WBSY: wait for BSY = 1, then go to WDV.
- WDV: wait for Dvld = 1, then Done pulses on the next cycle and state goes to IDLE.
- Bvld while Brdy = 0 is ignored, with no Err.
- Kout and Ivout hold stable from the last IV byte through Done, and they keep their contents in IDLE.
- Bfirst on a non-accepted cycle has no effect.

## Timing
- Reset values: state IDLE, cnt 0, Kout 0, Ivout 0, Krdy 0, Drdy 0, Done 0, Err 0. Brdy is 1 during and after reset.
- Reset asserted mid-load clears everything immediately. Krdy and Drdy drop asynchronously.
- Data path: 20 accepted bytes. Krdy is high in the cycle after the 20th byte is accepted.
- With Kvld one cycle after Krdy, Drdy is high 3 cycles after Krdy.
- Done is high 1 cycle after the cycle in which Dvld is sampled high.
- Ivout is valid before Krdy rises, because the core captures both key and IV on Krdy.
- Krdy and Drdy are never high in the same cycle.
- All outputs are registered except Brdy, which is decoded from state.

## Configuration
- TRIVIUM_LOADER_KEYREUSE_EN defined:
  - Bivonly is a live input.
  - An accepted Bfirst byte with Bivonly = 1 writes Ivout byte 0, sets cnt to 1 and goes to IV. Kout is retained.
  - The load sequence is otherwise unchanged; Krdy still pulses with the retained key.
- Not defined:
  - The Bivonly port is absent.
  - Every Bfirst load collects all 20 bytes.

## Test plan
- Reset, then 20 bytes 0x00..0x13 with Bfirst on byte 0x00, core model Kvld at +1 and Dvld 50 cycles after Drdy:
  - Kout = 0x09080706050403020100.
  - Ivout = 0x13121110_0F0E0D0C0B0A.
  - Krdy 1 cycle, Drdy 3 cycles later, Done 1 cycle after Dvld.
- Bvld with Bin = 0xAA, Bfirst = 0 in IDLE -> Err pulses once, state IDLE, Kout unchanged.
- 5 key bytes, then Bfirst with 0x55 and 19 more bytes -> Kout byte 0 = 0x55, Krdy after 20 bytes of the new load only.
- Bvld held high during WBSY/WDV with random bytes -> Brdy = 0, Kout and Ivout unchanged, no Err.
- RSTn low for 1 cycle in WKV -> all outputs 0, Brdy = 1, no Drdy; a following full load completes normally.
- KEYREUSE_EN: full load with key K, then Bfirst & Bivonly with 10 IV bytes -> Kout = K, Krdy after the 10th byte, Done issued.
